fetch_unit: RTL and testbench

//  Instruction fetch front end: consumes the program-counter value, issues instruction-memory reads

---
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// It issues word reads to instruction memory over a req/ack handshake.
// Returned words are buffered with their PCs in a small FIFO for decode.
// A redirect flushes the FIFO and reloads the fetch pointer. A request that
// is still outstanding at that point is completed and its data discarded.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready
);

  localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

  // IDLE: no request. WAIT: request whose data will be queued.
  // DROP: request orphaned by a redirect; its data is thrown away.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DROP = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_fptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_fptr_next;
  logic [ADDR_W-1:0] w_mem_addr_next;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic              w_inst_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_room;

  // Push/pop qualifiers and the occupancy the queue will have after this edge
  always_comb begin
    w_inst_valid = (r_count != {CNT_W{1'b0}});
    w_pop        = w_inst_valid & i_inst_ready;
    w_push       = (r_state == S_WAIT) & i_mem_ack & ~i_redirect_valid;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1'b1);
      2'b01:   w_count_next = r_count - CNT_W'(1'b1);
      default: w_count_next = r_count;
    endcase
    // A free slot is reserved before a request is issued, so a push never overflows.
    w_room = (w_count_next < DEPTH_C);
  end

  // Next state: a redirect overrides everything except completing an outstanding request
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!i_redirect_valid && w_room) begin
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_redirect_valid) begin
          if (i_mem_ack) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DROP;
          end
        end else if (i_mem_ack) begin
          if (w_room) begin
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_DROP: begin
        if (i_mem_ack) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DROP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Fetch pointer update. The presented address stays frozen while an orphaned request is held.
  always_comb begin
    if (i_redirect_valid) begin
      w_fptr_next = i_redirect_pc & ALIGN_MASK;
    end else if (w_push) begin
      w_fptr_next = r_fptr + PC_STEP;
    end else begin
      w_fptr_next = r_fptr;
    end
    if (w_state_next == S_DROP) begin
      w_mem_addr_next = r_mem_addr;
    end else begin
      w_mem_addr_next = w_fptr_next;
    end
  end

  // State, fetch pointer and request address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fptr     <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fptr     <= w_fptr_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  // Queue occupancy and pointers. A redirect empties the queue and discards this cycle's push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= {CNT_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
    end else if (i_redirect_valid) begin
      r_count  <= {CNT_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
    end
  end

  // Queue storage. Needs no reset: only entries below the occupancy count are ever shown.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= i_mem_rdata;
      r_q_pc[r_wr_ptr]   <= r_fptr;
    end
  end

  // Outputs decoded from registers. The head is forced to zero while the queue is empty.
  always_comb begin
    o_mem_req    = (r_state != S_IDLE);
    o_mem_addr   = r_mem_addr;
    o_inst_valid = w_inst_valid;
    if (w_inst_valid) begin
      o_inst    = r_q_data[r_rd_ptr];
      o_inst_pc = r_q_pc[r_rd_ptr];
    end else begin
      o_inst    = {DATA_W{1'b0}};
      o_inst_pc = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit.
// Expected PCs are queued ahead of each scenario. A negedge monitor pops one
// entry per accepted instruction and checks pc and data, where data is pc ^ 0xA5A5A5A5.
// The monitor also checks that an unacknowledged request holds its address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Memory model controls
  logic        man_mode;
  logic        man_ack;
  int unsigned ack_delay;
  int unsigned ack_cnt;

  int          n_checks;
  int          n_fail;
  logic [31:0] sb_pc[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_ack        (mem_ack),
    .i_mem_rdata      (mem_rdata),
    .o_inst_valid     (inst_valid),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .i_inst_ready     (inst_ready)
  );

  assign mem_rdata = mem_addr ^ 32'hA5A5A5A5;
  assign mem_ack   = mem_req && (man_mode ? man_ack : (ack_cnt >= ack_delay));

  // Count the cycles the current request has waited, for the delayed-ack memory
  always @(posedge clk or posedge rst) begin
    if (rst) ack_cnt <= 0;
    else if (!mem_req || mem_ack) ack_cnt <= 0;
    else ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget, output int n);
    n = 0;
    while (sb_pc.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_pc.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: got %0d entries still expected, required 0", name, sb_pc.size());
      sb_pc.delete();
    end
  endtask

  // Monitor: scoreboard pop on every accepted instruction, plus request-hold check
  initial begin : monitor
    logic        hold_prev;
    logic [31:0] addr_prev;
    logic [31:0] e;
    hold_prev = 1'b0;
    addr_prev = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_prev) begin
          check("hold_req", {31'h0, mem_req}, 32'h1);
          check("hold_addr", mem_addr, addr_prev);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (sb_pc.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_inst: got pc 0x%08h, required no instruction", inst_pc);
          end else begin
            e = sb_pc.pop_front();
            check("inst_pc", inst_pc, e);
            check("inst", inst, e ^ 32'hA5A5A5A5);
          end
        end
        hold_prev = mem_req && !mem_ack;
        addr_prev = mem_addr;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    man_mode = 1'b0;
    man_ack = 1'b0;
    ack_delay = 0;
    n_checks = 0;
    n_fail = 0;

    // 1: reset values, then zero-wait streaming at one instruction per cycle
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) sb_pc.push_back(32'(i * 4));
    repeat (2) tick();
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    rst = 1'b0;
    check("t1_req_at_release", {31'h0, mem_req}, 32'h0);
    tick();
    check("t1_first_req", {31'h0, mem_req}, 32'h1);
    check("t1_first_addr", mem_addr, 32'h0);
    wait_drain("t1", 30, n);
    check("t1_rate", 32'(n), 32'd9);
    inst_ready = 1'b0;

    // 2: back-pressure fills both slots and stops fetching; release resumes in order
    apply_reset();
    repeat (3) tick();
    check("t2_req_stopped", {31'h0, mem_req}, 32'h0);
    check("t2_next_addr", mem_addr, 32'h8);
    check("t2_valid", {31'h0, inst_valid}, 32'h1);
    check("t2_head_pc", inst_pc, 32'h0);
    check("t2_head_inst", inst, 32'hA5A5A5A5);
    repeat (2) tick();
    check("t2_req_still_stopped", {31'h0, mem_req}, 32'h0);
    check("t2_head_pc_held", inst_pc, 32'h0);
    for (int i = 0; i < 5; i++) sb_pc.push_back(32'(i * 4));
    inst_ready = 1'b1;
    wait_drain("t2", 30, n);
    inst_ready = 1'b0;

    // 3: each ack delayed three cycles; the request holds and nothing is valid early
    ack_delay = 3;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) sb_pc.push_back(32'(i * 4));
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_req", {31'h0, mem_req}, 32'h1);
      check("t3_addr", mem_addr, 32'h0);
      check("t3_no_valid", {31'h0, inst_valid}, 32'h0);
    end
    wait_drain("t3", 40, n);
    inst_ready = 1'b0;
    ack_delay = 0;

    // 4: redirect to 0x100 while waiting on 0x8; the orphaned ack arrives two cycles later
    man_mode = 1'b1;
    man_ack = 1'b1;
    inst_ready = 1'b1;
    sb_pc.push_back(32'h0);
    sb_pc.push_back(32'h100);
    sb_pc.push_back(32'h104);
    apply_reset();
    repeat (3) tick();
    check("t4_wait_addr", mem_addr, 32'h8);
    man_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", {31'h0, inst_valid}, 32'h0);
    check("t4_drop_req", {31'h0, mem_req}, 32'h1);
    check("t4_drop_addr", mem_addr, 32'h8);
    tick();
    check("t4_drop_addr2", mem_addr, 32'h8);
    check("t4_flushed2", {31'h0, inst_valid}, 32'h0);
    man_ack = 1'b1;
    tick();
    check("t4_idle_req", {31'h0, mem_req}, 32'h0);
    check("t4_idle_addr", mem_addr, 32'h100);
    check("t4_no_stale", {31'h0, inst_valid}, 32'h0);
    tick();
    check("t4_new_req", {31'h0, mem_req}, 32'h1);
    check("t4_new_addr", mem_addr, 32'h100);
    wait_drain("t4", 20, n);
    inst_ready = 1'b0;
    man_mode = 1'b0;

    // 5: redirect to the top word (low bits set) wraps to address zero
    inst_ready = 1'b1;
    sb_pc.push_back(32'hFFFFFFFC);
    sb_pc.push_back(32'h0);
    sb_pc.push_back(32'h4);
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFFFFFE;
    tick();
    redirect_valid = 1'b0;
    check("t5_idle_req", {31'h0, mem_req}, 32'h0);
    check("t5_aligned_addr", mem_addr, 32'hFFFFFFFC);
    tick();
    check("t5_req", {31'h0, mem_req}, 32'h1);
    check("t5_addr", mem_addr, 32'hFFFFFFFC);
    wait_drain("t5", 20, n);
    inst_ready = 1'b0;

    // 6: reset during a request with an ack pending, then redirect during push+pop
    man_mode = 1'b1;
    man_ack = 1'b1;
    apply_reset();
    repeat (2) tick();
    check("t6_pre_valid", {31'h0, inst_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_req", {31'h0, mem_req}, 32'h0);
    check("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
    check("t6_rst_pc", inst_pc, 32'h0);
    check("t6_rst_addr", mem_addr, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    sb_pc.push_back(32'h0);
    sb_pc.push_back(32'h4);
    inst_ready = 1'b1;
    wait_drain("t6a", 20, n);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    sb_pc.push_back(32'h200);
    sb_pc.push_back(32'h204);
    tick();
    redirect_valid = 1'b0;
    check("t6_redir_empty", {31'h0, inst_valid}, 32'h0);
    check("t6_redir_idle", {31'h0, mem_req}, 32'h0);
    check("t6_redir_addr", mem_addr, 32'h200);
    tick();
    check("t6_redir_req", {31'h0, mem_req}, 32'h1);
    check("t6_redir_req_addr", mem_addr, 32'h200);
    wait_drain("t6b", 20, n);
    inst_ready = 1'b0;
    man_mode = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
